// File: rtl/rgb_status_pwm_if.sv
// rtl/rgb_status_pwm_if.sv - game-state inputs and RGB LED drive bundle for rgb_status_pwm
interface rgb_status_pwm_if #(
    parameter int PWM_BITS = 8
);
    logic                gameOver;
    logic                i_speaker;
    logic [PWM_BITS-1:0] i_bright;
    logic                red;
    logic                green;
    logic                blue;

    modport master (
        output gameOver, i_speaker, i_bright,
        input  red, green, blue
    );

    modport slave (
        input  gameOver, i_speaker, i_bright,
        output red, green, blue
    );
endinterface

// File: rtl/rgb_status_pwm.sv
// rtl/rgb_status_pwm.sv - RGB status LED driver with PWM brightness, alert hold and game-over blink
module rgb_status_pwm #(
    parameter int PWM_BITS    = 8,
    parameter int HOLD_CYCLES = 5_000_000,
    parameter int BLINK_HALF  = 12_500_000,
    parameter bit BLINK_EN    = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    rgb_status_pwm_if.slave    bus
);
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [HW-1:0]       HOLD_LOAD  = HW'(HOLD_CYCLES);
    localparam logic [BW-1:0]       BLINK_LAST = BW'(BLINK_HALF - 1);
    // Last count value is 2^PWM_BITS-2, giving a period of 2^PWM_BITS-1 cycles.
    localparam logic [PWM_BITS-1:0] PWM_LAST   = {{(PWM_BITS-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALERT = 2'd1,
        OVER  = 2'd2
    } state_t;

    state_t              state, state_d;
    logic [HW-1:0]       hold_cnt, hold_d;
    logic [BW-1:0]       blink_cnt, blink_cnt_d;
    logic                blink_ph, blink_ph_d;
    logic [PWM_BITS-1:0] pwm_cnt, pwm_d;
    logic                pwm_on;
    logic                red_d, green_d, blue_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            hold_cnt  <= '0;
            blink_cnt <= '0;
            blink_ph  <= 1'b1;
            pwm_cnt   <= '0;
            bus.red   <= 1'b0;
            bus.green <= 1'b0;
            bus.blue  <= 1'b0;
        end else begin
            state     <= state_d;
            hold_cnt  <= hold_d;
            blink_cnt <= blink_cnt_d;
            blink_ph  <= blink_ph_d;
            pwm_cnt   <= pwm_d;
            bus.red   <= red_d;
            bus.green <= green_d;
            bus.blue  <= blue_d;
        end
    end

    always_comb begin
        state_d     = IDLE;
        hold_d      = '0;
        blink_cnt_d = blink_cnt;
        blink_ph_d  = blink_ph;

        if (bus.gameOver) begin
            state_d = OVER;
            if (state != OVER) begin
                blink_cnt_d = '0;
                blink_ph_d  = 1'b1;
            end else if (blink_cnt == BLINK_LAST) begin
                blink_cnt_d = '0;
                blink_ph_d  = BLINK_EN ? ~blink_ph : 1'b1;
            end else begin
                blink_cnt_d = blink_cnt + BW'(1);
            end
        end else if (bus.i_speaker) begin
            // Every speaker cycle reloads, so the hold always counts from the last pulse.
            state_d = ALERT;
            hold_d  = HOLD_LOAD;
        end else if (state == ALERT && hold_cnt > HW'(1)) begin
            state_d = ALERT;
            hold_d  = hold_cnt - HW'(1);
        end
    end

    always_comb begin
        pwm_d   = (pwm_cnt == PWM_LAST) ? '0 : pwm_cnt + PWM_BITS'(1);
        pwm_on  = (pwm_cnt < bus.i_bright);
        red_d   = (state == ALERT) && pwm_on;
        green_d = (state == IDLE)  && pwm_on;
        blue_d  = (state == OVER)  && pwm_on && blink_ph;
    end
endmodule

// File: tb/tb_rgb_status_pwm.sv
// tb/tb_rgb_status_pwm.sv - self-checking bench for rgb_status_pwm against a history-based model
module tb_rgb_status_pwm;
    localparam int PB    = 4;
    localparam int MAXC  = 15;
    localparam int HOLD  = 10;
    localparam int BH    = 20;
    localparam int DEPTH = 8192;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    rgb_status_pwm_if #(.PWM_BITS(PB)) bus ();

    rgb_status_pwm #(
        .PWM_BITS   (PB),
        .HOLD_CYCLES(HOLD),
        .BLINK_HALF (BH),
        .BLINK_EN   (1'b1)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Input history per clock edge since the last reset release (index 1 = first edge).
    bit go_h [DEPTH];
    bit sp_h [DEPTH];
    int br_h [DEPTH];
    int n = 0;

    // 0 = idle, 1 = alert, 2 = over : state after edge k, from the input history.
    function automatic int model_state(int k);
        if (k <= 0) return 0;
        if (go_h[k]) return 2;
        for (int j = k; j >= 1 && (k - j) < HOLD; j--) begin
            if (go_h[j]) return 0;
            if (sp_h[j]) return 1;
        end
        return 0;
    endfunction

    function automatic bit model_ph(int k);
        int e;
        e = k;
        while (e > 1 && go_h[e-1]) e--;
        return (((k - e) / BH) % 2) == 0;
    endfunction

    function automatic logic [2:0] model_rgb(int k);
        int  s;
        bit  on;
        s  = model_state(k - 1);
        on = ((k - 1) % MAXC) < br_h[k];
        return {(s == 1) && on, (s == 0) && on, (s == 2) && on && model_ph(k - 1)};
    endfunction

    task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s edge=%0d observed rgb=%b expected rgb=%b", tag, n, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input bit g, input bit s, input int b, output logic [2:0] rgb);
        bus.gameOver  = g;
        bus.i_speaker = s;
        bus.i_bright  = 4'(b);
        @(posedge clk);
        n++;
        go_h[n] = g;
        sp_h[n] = s;
        br_h[n] = b;
        #1;
        rgb = {bus.red, bus.green, bus.blue};
        check("rgb", rgb, model_rgb(n));
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        #1;
        check("rst_async", {bus.red, bus.green, bus.blue}, 3'b000);
        repeat (cycles) @(posedge clk);
        #1;
        check("rst_held", {bus.red, bus.green, bus.blue}, 3'b000);
        reset = 1'b0;
        n = 0;
    endtask

    task automatic run(input bit g, input bit s, input int b, input int cycles,
                       output int rc, output int gc, output int bc);
        logic [2:0] rgb;
        rc = 0; gc = 0; bc = 0;
        for (int i = 0; i < cycles; i++) begin
            step(g, s, b, rgb);
            rc += int'(rgb[2]);
            gc += int'(rgb[1]);
            bc += int'(rgb[0]);
        end
    endtask

    initial begin
        logic [2:0] rgb;
        int rc, gc, bc, rc2, gc2, bc2;
        bit g;

        bus.gameOver  = 1'b1;
        bus.i_speaker = 1'b0;
        bus.i_bright  = 4'd15;
        #2;
        do_reset(3);

        // Released into game-over: blue appears on the second edge.
        step(1, 0, 15, rgb);
        step(1, 0, 15, rgb);
        check("over_after_release", rgb, 3'b001);
        run(1, 0, 15, 10, rc, gc, bc);

        // Idle duty cycles over one full PWM period.
        run(0, 0, 5, 3, rc, gc, bc);
        run(0, 0, 5, MAXC, rc, gc, bc);
        check_int("green_duty5", gc, 5);
        run(0, 0, 0, 2, rc, gc, bc);
        run(0, 0, 0, MAXC, rc, gc, bc);
        check_int("green_duty0", gc, 0);
        run(0, 0, 15, 2, rc, gc, bc);
        run(0, 0, 15, MAXC, rc, gc, bc);
        check_int("green_duty15", gc, MAXC);

        // Single-cycle speaker pulse stretched to the hold time.
        run(0, 1, 15, 1, rc, gc, bc);
        run(0, 0, 15, 20, rc2, gc2, bc2);
        check_int("pulse_red", rc + rc2, HOLD);
        check_int("pulse_green", gc + gc2, 21 - HOLD);

        // Retrigger six cycles after the first pulse.
        run(0, 1, 15, 1, rc, gc, bc);
        run(0, 0, 15, 5, rc2, gc2, bc2);
        rc += rc2;
        run(0, 1, 15, 1, rc2, gc2, bc2);
        rc += rc2;
        run(0, 0, 15, 20, rc2, gc2, bc2);
        check_int("retrigger_red", rc + rc2, 6 + HOLD);

        // Game over during alert: blink 20 on / 20 off, then back to idle.
        run(0, 1, 15, 1, rc, gc, bc);
        run(0, 0, 15, 3, rc, gc, bc);
        run(1, 0, 15, 2, rc, gc, bc);
        run(1, 0, 15, 80, rc, gc, bc);
        check_int("blink_blue", bc, 40);
        check_int("blink_red", rc, 0);
        run(0, 0, 15, 20, rc, gc, bc);
        check_int("after_over_green", gc, 19);

        // Reset mid-alert and mid-blink.
        run(0, 1, 15, 1, rc, gc, bc);
        run(0, 0, 15, 3, rc, gc, bc);
        do_reset(2);
        run(0, 0, 15, 12, rc, gc, bc);
        check_int("post_rst_alert_red", rc, 0);
        run(1, 0, 15, 30, rc, gc, bc);
        do_reset(2);
        run(0, 0, 15, 12, rc, gc, bc);
        check_int("post_rst_over_blue", bc, 0);

        // Randomised traffic against the history model.
        g = 1'b0;
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 79) == 0) g = ~g;
            if ($urandom_range(0, 599) == 0) do_reset(2);
            step(g, ($urandom_range(0, 29) == 0), int'($urandom_range(0, 15)), rgb);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
